// File: rtl/fc2_mac_engine_pkg.sv
// -----------------------------------------------------------------------------
// fc2_pkg
// Shared types, Q-format widths and the round/saturate helper for the FC2
// dot-product engine. Activations, weights, bias and result are all signed
// Q8.8; the accumulator holds full-precision Q16.16 products summed over
// several beats.
// -----------------------------------------------------------------------------
package fc2_pkg;

  localparam int BIT_WIDTH = 16;               // activation/weight/result width
  localparam int FRAC_BITS = 8;                // fractional bits of every operand
  localparam int ACC_WIDTH = 40;               // >= 2*BIT_WIDTH+3+clog2(16)
  localparam int LANES     = 5;                // weight/activation lanes per beat
  localparam int DOT_WIDTH = 2*BIT_WIDTH + 3;  // one 5-lane dot product
  localparam int IDX_WIDTH = 4;                // RAM row index width

  localparam logic signed [ACC_WIDTH-1:0] RES_MAX    = ACC_WIDTH'((1 <<< (BIT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] RES_MIN    = ACC_WIDTH'(-(1 <<< (BIT_WIDTH-1)));
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1 <<< (FRAC_BITS-1));

  typedef enum logic [2:0] {IDLE, FETCH, ACCUM, ROUND, OUT} fc2_state_t;

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] data;    // saturated result
    logic                        sat_hi;  // clipped at the positive rail
    logic                        sat_lo;  // clipped at the negative rail
  } fc2_res_t;

  // Adds the bias (aligned to the accumulator's Q16.16 point), rounds half up
  // and drops back to Q8.8 with saturation.
  function automatic fc2_res_t sat_round(input logic signed [ACC_WIDTH-1:0] acc,
                                         input logic signed [BIT_WIDTH-1:0] bias);
    logic signed [ACC_WIDTH-1:0] bias_q;
    logic signed [ACC_WIDTH-1:0] t;
    logic signed [ACC_WIDTH-1:0] r;
    fc2_res_t res;
    bias_q     = ACC_WIDTH'(bias) <<< FRAC_BITS;
    t          = acc + bias_q + ROUND_HALF;
    r          = t >>> FRAC_BITS;
    res.sat_hi = (r > RES_MAX);
    res.sat_lo = (r < RES_MIN);
    if (res.sat_hi)
      res.data = RES_MAX[BIT_WIDTH-1:0];
    else if (res.sat_lo)
      res.data = RES_MIN[BIT_WIDTH-1:0];
    else
      res.data = r[BIT_WIDTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fc2_mac_engine_if.sv
// -----------------------------------------------------------------------------
// fc2_mac_engine_if
// Bundles every handshake/bus signal of the FC2 engine.
//   control : start (in), busy (out)
//   RAM     : wt_enable/wt_index (out), wt_bias, wt_0..wt_4 (in)
//   act     : act_valid, act_0..act_4 (in), act_ready (out)
//   result  : res_valid, res_data, res_sat (out), res_ready (in)
// Modport slave is the engine side; master is the surrounding system.
// -----------------------------------------------------------------------------
interface fc2_mac_engine_if;
  import fc2_pkg::*;

  logic                        start;
  logic                        busy;
  logic                        wt_enable;
  logic [IDX_WIDTH-1:0]        wt_index;
  logic signed [BIT_WIDTH-1:0] wt_bias;
  logic signed [BIT_WIDTH-1:0] wt_0, wt_1, wt_2, wt_3, wt_4;
  logic                        act_valid;
  logic                        act_ready;
  logic signed [BIT_WIDTH-1:0] act_0, act_1, act_2, act_3, act_4;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [BIT_WIDTH-1:0] res_data;
  logic                        res_sat;

  modport slave (
    input  start, wt_bias, wt_0, wt_1, wt_2, wt_3, wt_4,
           act_valid, act_0, act_1, act_2, act_3, act_4, res_ready,
    output busy, wt_enable, wt_index, act_ready, res_valid, res_data, res_sat
  );

  modport master (
    output start, wt_bias, wt_0, wt_1, wt_2, wt_3, wt_4,
           act_valid, act_0, act_1, act_2, act_3, act_4, res_ready,
    input  busy, wt_enable, wt_index, act_ready, res_valid, res_data, res_sat
  );

endinterface

// File: rtl/fc2_mac_engine_dot5.sv
// -----------------------------------------------------------------------------
// fc2_dot5
// Combinational 5-lane signed multiply followed by a small adder tree.
//   i_act[5] : signed activation lanes
//   i_wt[5]  : signed weight lanes
//   o_sum    : full-precision signed dot product, DOT_WIDTH bits
// -----------------------------------------------------------------------------
module fc2_dot5
  import fc2_pkg::*;
(
  input  logic signed [BIT_WIDTH-1:0] i_act [LANES],
  input  logic signed [BIT_WIDTH-1:0] i_wt  [LANES],
  output logic signed [DOT_WIDTH-1:0] o_sum
);

  logic signed [2*BIT_WIDTH-1:0] w_prod [LANES];
  logic signed [DOT_WIDTH-1:0]   w_sum01;
  logic signed [DOT_WIDTH-1:0]   w_sum23;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_prod[gi] = (2*BIT_WIDTH)'(i_act[gi]) * (2*BIT_WIDTH)'(i_wt[gi]);
    end
  endgenerate

  assign w_sum01 = DOT_WIDTH'(w_prod[0]) + DOT_WIDTH'(w_prod[1]);
  assign w_sum23 = DOT_WIDTH'(w_prod[2]) + DOT_WIDTH'(w_prod[3]);
  assign o_sum   = w_sum01 + w_sum23 + DOT_WIDTH'(w_prod[4]);

endmodule

// File: rtl/fc2_mac_engine.sv
// -----------------------------------------------------------------------------
// fc2_mac_engine
// Dot-product engine for the second fully-connected layer. Walks the FC2
// weight RAM rows 0..N_STEPS-1, multiplies each row's 5 weights with one
// activation beat, accumulates, then adds the bias, rounds, saturates and
// presents one Q8.8 result on a valid/ready handshake.
//   CLK, RST_N : clock and asynchronous active-low reset
//   bus        : fc2_mac_engine_if.slave (control, RAM, activation, result)
// Optional build macro FC2_RELU_EN: negative results become 0 and res_sat
// only reports positive clipping.
// -----------------------------------------------------------------------------
module fc2_mac_engine
  import fc2_pkg::*;
#(
  parameter int N_STEPS = 4  // beats per result, 1..16
) (
  input  logic            CLK,
  input  logic            RST_N,
  fc2_mac_engine_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_STEP = IDX_WIDTH'(N_STEPS - 1);

  fc2_state_t                  r_state;
  fc2_state_t                  w_state_next;
  logic [IDX_WIDTH-1:0]        r_step;
  logic [IDX_WIDTH-1:0]        r_index;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [BIT_WIDTH-1:0] r_res_data;
  logic                        r_res_sat;

  logic                        w_beat;
  logic                        w_last;
  logic signed [BIT_WIDTH-1:0] w_act [LANES];
  logic signed [BIT_WIDTH-1:0] w_wt  [LANES];
  logic signed [DOT_WIDTH-1:0] w_dot;
  fc2_res_t                    w_rnd;
  logic signed [BIT_WIDTH-1:0] w_res_data;
  logic                        w_res_sat;

  assign w_act[0] = bus.act_0;
  assign w_act[1] = bus.act_1;
  assign w_act[2] = bus.act_2;
  assign w_act[3] = bus.act_3;
  assign w_act[4] = bus.act_4;
  assign w_wt[0]  = bus.wt_0;
  assign w_wt[1]  = bus.wt_1;
  assign w_wt[2]  = bus.wt_2;
  assign w_wt[3]  = bus.wt_3;
  assign w_wt[4]  = bus.wt_4;

  fc2_dot5 u_dot (
    .i_act (w_act),
    .i_wt  (w_wt),
    .o_sum (w_dot)
  );

  // act_ready is high exactly in ACCUM, so a beat is ACCUM plus act_valid.
  assign w_beat = (r_state == ACCUM) && bus.act_valid;
  assign w_last = (r_step == LAST_STEP);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start)          w_state_next = FETCH;
      FETCH:                           w_state_next = ACCUM;
      ACCUM:   if (w_beat && w_last)   w_state_next = ROUND;
      ROUND:                           w_state_next = OUT;
      OUT:     if (bus.res_ready)      w_state_next = IDLE;
      default:                         w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy      = (r_state != IDLE);
    bus.wt_enable = (r_state == FETCH) || (r_state == ACCUM);
    bus.act_ready = (r_state == ACCUM);
    bus.res_valid = (r_state == OUT);
  end

  assign bus.wt_index = r_index;
  assign bus.res_data = r_res_data;
  assign bus.res_sat  = r_res_sat;

  // Final rounding. The RAM still presents row N_STEPS-1 during ROUND; the
  // bias column is identical in every row, so that read is valid.
  always_comb begin
    w_rnd = sat_round(r_acc, bus.wt_bias);
`ifdef FC2_RELU_EN
    w_res_data = w_rnd.data[BIT_WIDTH-1] ? '0 : w_rnd.data;
    w_res_sat  = w_rnd.sat_hi;
`else
    w_res_data = w_rnd.data;
    w_res_sat  = w_rnd.sat_hi | w_rnd.sat_lo;
`endif
  end

  // Accumulator, step counter, RAM index and result register. The index is
  // advanced on the same edge as the beat so the RAM's negedge latch has the
  // next row ready for a back-to-back beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc      <= '0;
      r_step     <= '0;
      r_index    <= '0;
      r_res_data <= '0;
      r_res_sat  <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_acc   <= '0;
        r_step  <= '0;
        r_index <= '0;
      end
      if (w_beat) begin
        r_acc <= r_acc + ACC_WIDTH'(w_dot);
        if (!w_last) begin
          r_step  <= r_step + 1'b1;
          r_index <= r_step + 1'b1;
        end
      end
      if (r_state == ROUND) begin
        r_res_data <= w_res_data;
        r_res_sat  <= w_res_sat;
      end
    end
  end

endmodule

// File: tb/tb_fc2_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_fc2_mac_engine
// Self-checking bench for fc2_mac_engine: negedge-latching RAM model with
// bias 29, a plain-arithmetic reference for the dot product / round /
// saturate, directed scenarios and randomized runs.
// -----------------------------------------------------------------------------
module tb_fc2_mac_engine;
  import fc2_pkg::*;

  localparam int N    = 4;
  localparam int BIAS = 29;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc2_mac_engine_if bus();

  fc2_mac_engine #(.N_STEPS(N)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] wt_tab   [5][16];
  logic signed [15:0] beat_act [16][5];
  logic [3:0]         ram_row = '0;

  // RAM model: latches the index on negedge while enabled.
  always @(negedge clk) if (bus.wt_enable) ram_row <= bus.wt_index;

  assign bus.wt_bias = 16'(BIAS);
  assign bus.wt_0    = wt_tab[0][ram_row];
  assign bus.wt_1    = wt_tab[1][ram_row];
  assign bus.wt_2    = wt_tab[2][ram_row];
  assign bus.wt_3    = wt_tab[3][ram_row];
  assign bus.wt_4    = wt_tab[4][ram_row];

  task automatic check_value(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, bias in Q16.16, round half up,
  // floor-shift back to Q8.8, clip to 16-bit signed.
  function automatic void model_result(output longint exp_data, output longint exp_sat);
    longint acc;
    longint r;
    acc = 0;
    for (int b = 0; b < N; b++)
      for (int l = 0; l < 5; l++)
        acc += longint'(beat_act[b][l]) * longint'(wt_tab[l][b]);
    r       = (acc + BIAS * 256 + 128) >>> 8;
    exp_sat = 0;
    if (r > 32767) begin
      r = 32767; exp_sat = 1;
    end else if (r < -32768) begin
      r = -32768; exp_sat = 1;
    end
`ifdef FC2_RELU_EN
    if (r < 0) begin
      r = 0; exp_sat = 0;
    end
`endif
    exp_data = r;
  endfunction

  // mode 0: zeros, 1: act_0=256, 2: act_0=32767, 3: full-range random, 4: small random
  task automatic set_beats(input int mode);
    for (int b = 0; b < 16; b++)
      for (int l = 0; l < 5; l++) begin
        case (mode)
          1:       beat_act[b][l] = (l == 0) ? 16'sd256 : 16'sd0;
          2:       beat_act[b][l] = (l == 0) ? 16'sd32767 : 16'sd0;
          3:       beat_act[b][l] = 16'($urandom_range(0, 65535));
          4:       beat_act[b][l] = 16'($signed($urandom_range(0, 1024)) - 512);
          default: beat_act[b][l] = 16'sd0;
        endcase
      end
  endtask

  task automatic drive_acts(input int beat);
    bus.act_0 = beat_act[beat][0];
    bus.act_1 = beat_act[beat][1];
    bus.act_2 = beat_act[beat][2];
    bus.act_3 = beat_act[beat][3];
    bus.act_4 = beat_act[beat][4];
  endtask

  task automatic apply_reset();
    bus.start = 0; bus.act_valid = 0; bus.res_ready = 0;
    rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  // One complete result. vmode 0: valid always, 1: 1,0,0 pattern, 2: random.
  task automatic do_run(input int vmode, input int stall, input bit hold_start,
                        input bit poke_start, input int exp_lat, output longint got);
    longint ed, es;
    int beat, toggle, cyc;
    bit hs, v;
    model_result(ed, es);
    beat = 0; toggle = 0; got = 0;
    bus.res_ready = (stall == 0);
    bus.start = 1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 0;
    check_value("fetch_index", bus.wt_index, 0);
    check_value("fetch_enable", bus.wt_enable, 1);
    for (cyc = 0; cyc < 200; cyc++) begin
      if (bus.res_valid) break;
      hs = 0;
      if (poke_start) bus.start = 1'($urandom_range(0, 1));
      if (bus.act_ready && beat < N) begin
        case (vmode)
          0:       v = 1;
          1:       v = (toggle % 3 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        toggle++;
        drive_acts(beat);
        bus.act_valid = v;
        if (v) begin
          check_value("beat_index", bus.wt_index, beat);
          hs = 1;
        end
      end else begin
        bus.act_valid = 0;
      end
      @(posedge clk); #1;
      if (hs) beat++;
    end
    bus.act_valid = 0;
    if (cyc >= 200) begin
      check_value("res_timeout", 0, 1);
      apply_reset();
      return;
    end
    if (exp_lat > 0) check_value("latency", cyc, exp_lat);
    check_value("beats", beat, N);
    got = longint'(bus.res_data);
    check_value("res_data", longint'(bus.res_data), ed);
    check_value("res_sat", bus.res_sat, es);
    for (int s = 0; s < stall; s++) begin
      if (poke_start) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_value("stall_valid", bus.res_valid, 1);
      check_value("stall_data", longint'(bus.res_data), ed);
    end
    bus.res_ready = 1;
    if (poke_start) bus.start = 1;
    @(posedge clk); #1;
    check_value("exit_valid", bus.res_valid, 0);
    check_value("exit_busy", bus.busy, 0);
    if (!hold_start) bus.start = 0;
    $display("run vmode=%0d stall=%0d data=%0d sat=%0d exp=%0d/%0d", vmode, stall, got, bus.res_sat, ed, es);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got;
    int     beat;
    bit     hs;
    int     lanes_init [4] = '{-316, 267, -359, -297};

    bus.start = 0; bus.act_valid = 0; bus.res_ready = 0;
    drive_acts(0);
    for (int r = 0; r < 16; r++) begin
      wt_tab[0][r] = (r < 4) ? 16'(lanes_init[r]) : 16'sd0;
      for (int l = 1; l < 5; l++) wt_tab[l][r] = 16'($urandom_range(0, 65535));
    end
    set_beats(0);
    drive_acts(0);

    // Reset state
    #2;
    check_value("rst_busy", bus.busy, 0);
    check_value("rst_wt_enable", bus.wt_enable, 0);
    check_value("rst_act_ready", bus.act_ready, 0);
    check_value("rst_res_valid", bus.res_valid, 0);
    check_value("rst_wt_index", bus.wt_index, 0);
    check_value("rst_res_data", longint'(bus.res_data), 0);
    check_value("rst_res_sat", bus.res_sat, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // 1: zero activations -> bias only
    set_beats(0);
    do_run(0, 0, 0, 0, N + 2, got);
    check_value("s1_const", got, BIAS);

    // 2: act_0 = 1.0
    set_beats(1);
    do_run(0, 0, 0, 0, N + 2, got);
`ifdef FC2_RELU_EN
    check_value("s2_const", got, 0);
`else
    check_value("s2_const", got, -676);
`endif

    // 3: act_0 = max -> negative saturation
    set_beats(2);
    do_run(0, 0, 0, 0, N + 2, got);
`ifdef FC2_RELU_EN
    check_value("s3_const", got, 0);
`else
    check_value("s3_const", got, -32768);
    check_value("s3_sat", bus.res_sat, 1);
`endif

    // 4: sparse valid, stalled result, stray start pulses
    set_beats(4);
    do_run(1, 5, 0, 1, 0, got);

    // 5: reset after two accepted beats
    set_beats(1);
    bus.res_ready = 1;
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 2; c++) begin
      hs = bus.act_ready;
      drive_acts(beat);
      bus.act_valid = 1;
      @(posedge clk); #1;
      if (hs) beat++;
    end
    check_value("s5_beats", beat, 2);
    rst_n = 0;
    #1;
    check_value("s5_wt_enable", bus.wt_enable, 0);
    check_value("s5_act_ready", bus.act_ready, 0);
    check_value("s5_busy", bus.busy, 0);
    check_value("s5_wt_index", bus.wt_index, 0);
    bus.act_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    do_run(0, 0, 0, 0, N + 2, got);
`ifdef FC2_RELU_EN
    check_value("s5_rerun", got, 0);
`else
    check_value("s5_rerun", got, -676);
`endif

    // 6: start held high across two back-to-back runs
    set_beats(4);
    do_run(0, 0, 1, 0, N + 2, got);
    set_beats(3);
    do_run(0, 0, 1, 0, N + 2, got);
    bus.start = 0;
    @(posedge clk); #1;

    // Randomized runs
    for (int k = 0; k < 12; k++) begin
      set_beats((k % 2 == 0) ? 4 : 3);
      do_run(2, $urandom_range(0, 3), 0, 1, 0, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
